// File: rtl/bitstream_pkg.sv
// Shared definitions for the byte/bitstream conversion path (serializer and deserializer).
package bitstream_pkg;

  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy count.
module byte_fifo
  import bitstream_pkg::*;
#(
  parameter  int unsigned WIDTH = BYTE_W,
  parameter  int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int unsigned CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Guard internally so a push while full or a pop while empty is ignored.
  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/byte_to_bitstream.sv
// Byte-to-serial converter: FIFO-buffered bytes emitted LSB-first, one bit per paced strobe.
module byte_to_bitstream
  import bitstream_pkg::*;
#(
  parameter int unsigned IN_SIZE        = BYTE_W,
  parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int unsigned CYCLES_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_SIZE-1:0] data_in,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  output logic               data_out,
  output logic               data_out_valid,
  output logic               tx_busy
);

  localparam int unsigned BIT_W  = clog2_min1(IN_SIZE);
  localparam int unsigned PACE_W = clog2_min1(CYCLES_PER_BIT);
  localparam int unsigned CNT_W  = clog2_min1(FIFO_DEPTH + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(IN_SIZE - 1);
  localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(CYCLES_PER_BIT - 1);

  tx_state_e          state_q, state_d;
  logic [IN_SIZE-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PACE_W-1:0]  pace_cnt_q, pace_cnt_d;
  logic               data_out_q, data_out_d;
  logic               data_out_valid_q, data_out_valid_d;

  logic [IN_SIZE-1:0] fifo_dout;
  logic               fifo_empty, fifo_full, fifo_pop;
  logic [CNT_W-1:0]   fifo_count;

  byte_fifo #(
    .WIDTH (IN_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .wr_en (data_in_valid),
    .din   (data_in),
    .rd_en (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign data_in_ready  = ~fifo_full;
  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  // The registered valid term keeps busy high while the final bit is still on the output.
  assign tx_busy = (state_q == ST_SHIFT) | (fifo_count != '0) | data_out_valid_q;

  always_comb begin
    state_d          = state_q;
    shreg_d          = shreg_q;
    bit_cnt_d        = bit_cnt_q;
    pace_cnt_d       = pace_cnt_q;
    data_out_d       = 1'b0;
    data_out_valid_d = 1'b0;
    fifo_pop         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_d    = fifo_dout;
          bit_cnt_d  = '0;
          pace_cnt_d = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (pace_cnt_q == '0) begin
          data_out_d       = shreg_q[bit_cnt_q];
          data_out_valid_d = 1'b1;
        end
        if ((bit_cnt_q == BIT_LAST) && (pace_cnt_q == PACE_LAST)) begin
          bit_cnt_d  = '0;
          pace_cnt_d = '0;
          // Reloading here, rather than via IDLE, keeps back-to-back bytes gap-free.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (pace_cnt_q == PACE_LAST) begin
          pace_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        end else begin
          pace_cnt_d = pace_cnt_q + PACE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      shreg_q          <= '0;
      bit_cnt_q        <= '0;
      pace_cnt_q       <= '0;
      data_out_q       <= 1'b0;
      data_out_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      shreg_q          <= shreg_d;
      bit_cnt_q        <= bit_cnt_d;
      pace_cnt_q       <= pace_cnt_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
    end
  end

endmodule

// File: tb/tb_byte_to_bitstream.sv
// Directed bench for byte_to_bitstream; four instances cover CYCLES_PER_BIT = 1, 2, 3 and 5.
module tb_byte_to_bitstream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din [4];
  logic [3:0] vin;
  wire  [3:0] rdy, dout, dval, busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         acc_at_full;
  bit         timed_out;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned CPB = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 5;
    byte_to_bitstream #(
      .IN_SIZE        (8),
      .FIFO_DEPTH     (4),
      .CYCLES_PER_BIT (CPB)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (din[g]),
      .data_in_valid  (vin[g]),
      .data_in_ready  (rdy[g]),
      .data_out       (dout[g]),
      .data_out_valid (dval[g]),
      .tx_busy        (busy[g])
    );
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents byte b on instance i from a falling edge; returns just after the accepting rising edge.
  task automatic drive_byte(input int i, input logic [7:0] b);
    @(negedge clk);
    din[i] = b;
    vin[i] = 1'b1;
    @(posedge clk);
  endtask

  // Pushes tx_q into instance i (optional random gaps) while reassembling output bits into rx_q.
  task automatic stream_bytes(input int i, input int gap_max, input int budget);
    int         idx    = 0;
    int         gap    = 0;
    int         cyc    = 0;
    int         bitpos = 0;
    logic [7:0] accb   = '0;
    bit         take;
    rx_q.delete();
    acc_at_full = -1;
    while ((rx_q.size() < tx_q.size()) && (cyc < budget)) begin
      @(negedge clk);
      cyc++;
      if (dval[i]) begin
        accb[bitpos] = dout[i];
        bitpos++;
        if (bitpos == 8) begin
          rx_q.push_back(accb);
          bitpos = 0;
        end
      end
      if (!rdy[i] && (acc_at_full < 0)) acc_at_full = idx;
      if ((idx < tx_q.size()) && (gap == 0)) begin
        vin[i] = 1'b1;
        din[i] = tx_q[idx];
      end else begin
        vin[i] = 1'b0;
        if (gap > 0) gap--;
      end
      take = vin[i] && rdy[i];
      @(posedge clk);
      if (take) begin
        idx++;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      end
    end
    @(negedge clk);
    vin[i] = 1'b0;
    timed_out = (rx_q.size() < tx_q.size());
  endtask

  task automatic test_reset;
    rst = 1'b0;
    vin = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rdy[i] !== 1'b1) begin errors++; $display("FAIL reset_ready inst=%0d got=%b exp=1", i, rdy[i]); end
      checks++; if (dval[i] !== 1'b0) begin errors++; $display("FAIL reset_valid inst=%0d got=%b exp=0", i, dval[i]); end
      checks++; if (dout[i] !== 1'b0) begin errors++; $display("FAIL reset_dout inst=%0d got=%b exp=0", i, dout[i]); end
      checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy inst=%0d got=%b exp=0", i, busy[i]); end
    end
  endtask

  task automatic test_single_byte;
    logic [7:0] b = 8'hA5;
    bit exp_v, exp_d;
    drive_byte(0, b);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vin[0] = 1'b0;
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", rdy[0]); end
      end
      exp_v = (k >= 3) && (k <= 10);
      exp_d = exp_v ? b[k-3] : 1'b0;
      checks++; if (dval[0] !== exp_v) begin errors++; $display("FAIL single_valid k=%0d got=%b exp=%b", k, dval[0], exp_v); end
      checks++; if (dout[0] !== exp_d) begin errors++; $display("FAIL single_dout k=%0d got=%b exp=%b", k, dout[0], exp_d); end
      if (k == 10) begin
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy_last got=%b exp=1", busy[0]); end
      end
      if (k == 11) begin
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b exp=0", busy[0]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s = 16'h8001;
    bit exp_v, exp_d;
    drive_byte(0, 8'h01);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) din[0] = 8'h80;
      if (k == 2) vin[0] = 1'b0;
      exp_v = (k >= 3) && (k <= 18);
      exp_d = exp_v ? s[k-3] : 1'b0;
      checks++; if (dval[0] !== exp_v) begin errors++; $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, dval[0], exp_v); end
      checks++; if (dout[0] !== exp_d) begin errors++; $display("FAIL b2b_dout k=%0d got=%b exp=%b", k, dout[0], exp_d); end
    end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_busy_after got=%b exp=0", busy[0]); end
  endtask

  task automatic test_slow_pace;
    int pulses = 0;
    bit exp_v;
    drive_byte(2, 8'hFF);
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if (k == 1) vin[2] = 1'b0;
      exp_v = (k >= 3) && (k <= 24) && (((k - 3) % 3) == 0);
      if (dval[2]) pulses++;
      checks++; if (dval[2] !== exp_v) begin errors++; $display("FAIL cpb3_valid k=%0d got=%b exp=%b", k, dval[2], exp_v); end
      checks++; if (dout[2] !== exp_v) begin errors++; $display("FAIL cpb3_dout k=%0d got=%b exp=%b", k, dout[2], exp_v); end
      if (k == 25) begin
        checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL cpb3_busy_tail got=%b exp=1", busy[2]); end
      end
      if (k == 26) begin
        checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL cpb3_busy_after got=%b exp=0", busy[2]); end
      end
    end
    checks++; if (pulses != 8) begin errors++; $display("FAIL cpb3_pulses got=%0d exp=8", pulses); end
  endtask

  task automatic test_fifo_full;
    logic [7:0] got;
    tx_q.delete();
    for (int j = 0; j < 8; j++) tx_q.push_back(8'(8'h10 + j));
    stream_bytes(0, 0, 300);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL full_timeout got=%0d bytes exp=8", rx_q.size()); end
    checks++; if (acc_at_full != 5) begin errors++; $display("FAIL full_ready_drop accepted=%0d exp=5", acc_at_full); end
    for (int j = 0; j < 8; j++) begin
      got = (j < rx_q.size()) ? rx_q[j] : 8'hxx;
      checks++; if (got !== tx_q[j]) begin errors++; $display("FAIL full_order byte=%0d got=%h exp=%h", j, got, tx_q[j]); end
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++; if (dval[0] !== 1'b0) begin errors++; $display("FAIL full_extra_bit k=%0d got=%b exp=0", k, dval[0]); end
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] got;
    drive_byte(0, 8'h3C);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) din[0] = 8'h99;
      if (k == 2) vin[0] = 1'b0;
    end
    checks++; if (dval[0] !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got=%b exp=1", dval[0]); end
    checks++; if (dout[0] !== 1'b1) begin errors++; $display("FAIL arst_pre_bit3 got=%b exp=1", dout[0]); end
    #2 rst = 1'b0;
    #1;
    checks++; if (dval[0] !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", dval[0]); end
    checks++; if (dout[0] !== 1'b0) begin errors++; $display("FAIL arst_dout got=%b exp=0", dout[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", busy[0]); end
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", rdy[0]); end
    @(negedge clk);
    rst = 1'b1;
    tx_q.delete();
    tx_q.push_back(8'hC3);
    stream_bytes(0, 0, 100);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    checks++; if (got !== 8'hC3) begin errors++; $display("FAIL arst_after_byte got=%h exp=c3", got); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++; if (dval[0] !== 1'b0) begin errors++; $display("FAIL arst_stale_bit k=%0d got=%b exp=0", k, dval[0]); end
    end
  endtask

  task automatic test_random_gaps;
    int         inst_tab [3] = '{0, 1, 3};
    logic [7:0] got;
    for (int t = 0; t < 3; t++) begin
      tx_q.delete();
      for (int j = 0; j < 10; j++) tx_q.push_back(8'($urandom_range(0, 255)));
      stream_bytes(inst_tab[t], 4, 3000);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rand_timeout inst=%0d got=%0d bytes exp=10", inst_tab[t], rx_q.size()); end
      for (int j = 0; j < 10; j++) begin
        got = (j < rx_q.size()) ? rx_q[j] : 8'hxx;
        checks++; if (got !== tx_q[j]) begin errors++; $display("FAIL rand_byte inst=%0d byte=%0d got=%h exp=%h", inst_tab[t], j, got, tx_q[j]); end
      end
      repeat (12) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_slow_pace();
    repeat (3) @(negedge clk);
    test_fifo_full();
    test_async_reset();
    test_random_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
